// File: rtl/flash_seq_ctrl.sv
// rtl/flash_seq_ctrl.sv - JEDEC check, sector erase, page program and read-back verify sequencer
// Drives flash_spi one command at a time and waits for Done_Sig before moving on.
module flash_seq_ctrl #(
   parameter int unsigned NUM_PAGES    = 4,
   parameter logic [23:0] BASE_ADDR    = 24'h000000,
   parameter logic [23:0] JEDEC_ID     = 24'hEF4017,
   parameter int unsigned GAP_CYCLES   = 100,
   parameter logic [23:0] POLL_TIMEOUT = 24'd4000000
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [2:0]  err_code,
   output logic [23:0] fail_addr,
   output logic [23:0] id_o,
   output logic [3:0]  cmd_type,
   output logic [7:0]  flash_cmd,
   output logic [23:0] flash_addr,
   input  logic        Done_Sig,
   input  logic [7:0]  mydata_o,
   input  logic        myvalid_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_RDID, S_WREN, S_SE, S_GAP, S_POLL, S_WRDI, S_POLL2,
      S_PWREN, S_PP, S_READ, S_DONE, S_ERR
   } state_t;

   localparam logic [8:0] NUM_PG   = 9'(NUM_PAGES);
   localparam logic [8:0] LAST_PG  = 9'(NUM_PAGES - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t      state;
   logic        issued;
   logic        mism;
   logic [8:0]  pg;
   logic [8:0]  byte_cnt;
   logic [7:0]  gap_cnt;
   logic [23:0] poll_cnt;

   logic [3:0]  cmd_t;
   logic [7:0]  cmd_op;
   logic [23:0] cmd_ad;
   logic [23:0] page_addr;
   logic [23:0] id_next;
   logic [8:0]  rd_total;
   logic        byte_bad;
   logic        mism_now;

   assign page_addr = BASE_ADDR + {7'd0, pg, 8'd0};
   assign id_next   = myvalid_o ? {id_o[15:0], mydata_o} : id_o;
   assign byte_bad  = myvalid_o && (mydata_o != byte_cnt[7:0]);
   assign rd_total  = byte_cnt + {8'd0, myvalid_o};
   assign mism_now  = mism | byte_bad;

   always_comb begin
      cmd_t  = 4'b0000;
      cmd_op = 8'h00;
      cmd_ad = 24'h000000;
      case (state)
         S_RDID:           begin cmd_t = 4'b1000; cmd_op = 8'h9F; end
         S_WREN, S_PWREN:  begin cmd_t = 4'b1001; cmd_op = 8'h06; end
         S_SE:             begin cmd_t = 4'b1010; cmd_op = 8'hD8; cmd_ad = BASE_ADDR; end
         S_POLL, S_POLL2:  begin cmd_t = 4'b1011; cmd_op = 8'h05; end
         S_WRDI:           begin cmd_t = 4'b1100; cmd_op = 8'h04; end
         S_PP:             begin cmd_t = 4'b1101; cmd_op = 8'h02; cmd_ad = page_addr; end
         S_READ:           begin cmd_t = 4'b1110; cmd_op = 8'h03; cmd_ad = page_addr; end
         default:          begin cmd_t = 4'b0000; end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state      <= S_IDLE;
         issued     <= 1'b0;
         mism       <= 1'b0;
         pg         <= 9'd0;
         byte_cnt   <= 9'd0;
         gap_cnt    <= 8'd0;
         poll_cnt   <= 24'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_code   <= 3'd0;
         fail_addr  <= 24'd0;
         id_o       <= 24'd0;
         cmd_type   <= 4'd0;
         flash_cmd  <= 8'd0;
         flash_addr <= 24'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state     <= S_RDID;
                  issued    <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_code  <= 3'd0;
                  fail_addr <= 24'd0;
                  pg        <= 9'd0;
                  poll_cnt  <= 24'd0;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) state <= S_POLL;
               else                     gap_cnt <= gap_cnt + 8'd1;
            end
            default: begin
               if (!issued) begin
                  // Entering a command state always follows at least one idle cycle.
                  cmd_type   <= cmd_t;
                  flash_cmd  <= cmd_op;
                  flash_addr <= cmd_ad;
                  issued     <= 1'b1;
                  byte_cnt   <= 9'd0;
                  mism       <= 1'b0;
               end else begin
                  if (state == S_RDID && myvalid_o) id_o <= id_next;
                  if (state == S_READ && myvalid_o) begin
                     if (!mism && byte_bad) begin
                        mism      <= 1'b1;
                        fail_addr <= page_addr + {16'd0, byte_cnt[7:0]};
                     end
                     byte_cnt <= byte_cnt + 9'd1;
                  end
                  if (Done_Sig) begin
                     issued     <= 1'b0;
                     cmd_type   <= 4'd0;
                     flash_cmd  <= 8'd0;
                     flash_addr <= 24'd0;
                     case (state)
                        S_RDID: begin
                           if (JEDEC_ID != 24'd0 && id_next != JEDEC_ID) begin
                              state <= S_ERR; err_code <= 3'd1; busy <= 1'b0; done <= 1'b1;
                           end else begin
                              state <= S_WREN;
                           end
                        end
                        S_WREN:  state <= S_SE;
                        S_PWREN: state <= S_PP;
                        S_WRDI:  state <= S_POLL2;
                        S_SE: begin
                           state   <= S_GAP;
                           gap_cnt <= 8'd0;
                        end
                        S_PP: begin
                           state   <= S_GAP;
                           gap_cnt <= 8'd0;
                           pg      <= pg + 9'd1;
                        end
                        S_POLL, S_POLL2: begin
                           if (mydata_o[0]) begin
                              if (poll_cnt + 24'd1 == POLL_TIMEOUT) begin
                                 state <= S_ERR; err_code <= 3'd2; busy <= 1'b0; done <= 1'b1;
                              end else begin
                                 poll_cnt <= poll_cnt + 24'd1;
                              end
                           end else begin
                              poll_cnt <= 24'd0;
                              if (state == S_POLL) begin
                                 state <= S_WRDI;
                              end else if (pg == NUM_PG) begin
                                 state <= S_READ;
                                 pg    <= 9'd0;
                              end else begin
                                 state <= S_PWREN;
                              end
                           end
                        end
                        S_READ: begin
                           if (mism_now) begin
                              state <= S_ERR; err_code <= 3'd3; busy <= 1'b0; done <= 1'b1;
                           end else if (rd_total != 9'd256) begin
                              state <= S_ERR; err_code <= 3'd4; busy <= 1'b0; done <= 1'b1;
                           end else if (pg == LAST_PG) begin
                              state <= S_DONE; pass <= 1'b1; busy <= 1'b0; done <= 1'b1;
                           end else begin
                              pg <= pg + 9'd1;
                           end
                        end
                        default: state <= S_ERR;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// tb/tb_flash_seq_ctrl.sv - randomized bench for flash_seq_ctrl with a behavioural flash_spi model
module tb_flash_seq_ctrl;

   localparam int          NPG  = 2;
   localparam logic [23:0] BASE = 24'h000000;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass;
   logic [2:0]  err_code;
   logic [23:0] fail_addr, id_o, flash_addr;
   logic [3:0]  cmd_type;
   logic [7:0]  flash_cmd;
   logic        Done_Sig;
   logic [7:0]  mydata_o;
   logic        myvalid_o;

   int total = 0;
   int bad   = 0;

   flash_seq_ctrl #(
      .NUM_PAGES(NPG), .BASE_ADDR(BASE), .JEDEC_ID(24'hEF4017),
      .GAP_CYCLES(4), .POLL_TIMEOUT(24'd8)
   ) dut (
      .CLK(CLK), .RSTn(RSTn), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_code(err_code), .fail_addr(fail_addr), .id_o(id_o), .cmd_type(cmd_type),
      .flash_cmd(flash_cmd), .flash_addr(flash_addr), .Done_Sig(Done_Sig),
      .mydata_o(mydata_o), .myvalid_o(myvalid_o)
   );

   always #5 CLK = ~CLK;

   // flash model configuration
   logic [23:0] model_id;
   int          read_len;
   bit          wip_stuck, spurious, corrupt_en;
   logic [23:0] corrupt_page;
   int          corrupt_idx;
   int          plan[$];
   int          plan_ref[$];
   logic [35:0] cmd_log[$];
   logic [35:0] exp_q[$];
   int          hold_err;

   // flash model state
   bit          m_act, zero_chk, wip_now;
   logic [35:0] cap;
   int          m_wait, m_idx, n_bytes, wip_left;
   logic [3:0]  prev_ct;

   function automatic logic [7:0] model_byte(input logic [35:0] c, input int i);
      logic [7:0]  b;
      logic [23:0] mid;
      if (c[35:32] == 4'b1000) begin
         mid = model_id;
         b = mid[23-8*i -: 8];
      end else begin
         b = i[7:0];
         if (corrupt_en && c[23:0] == corrupt_page && i == corrupt_idx) b = b ^ 8'h5A;
      end
      return b;
   endfunction

   initial begin
      Done_Sig = 1'b0; myvalid_o = 1'b0; mydata_o = 8'h00;
      m_act = 0; zero_chk = 0; prev_ct = 4'd0; wip_left = 0;
      forever begin
         @(negedge CLK);
         Done_Sig = 1'b0; myvalid_o = 1'b0; mydata_o = 8'h00;
         if (!RSTn) begin
            m_act = 0; zero_chk = 0;
         end else if (zero_chk) begin
            zero_chk = 0;
            if (cmd_type !== 4'd0 || flash_cmd !== 8'd0) hold_err++;
            if (spurious) begin Done_Sig = 1'b1; mydata_o = 8'h01; end
         end else if (!m_act) begin
            if (cmd_type != 4'd0) begin
               m_act = 1;
               cap = {cmd_type, flash_cmd, flash_addr};
               cmd_log.push_back(cap);
               m_wait = $urandom_range(0, 3);
               m_idx = 0;
               n_bytes = (cmd_type == 4'b1000) ? 3 : (cmd_type == 4'b1110) ? read_len : 0;
               if (cmd_type == 4'b1011) begin
                  if (prev_ct != 4'b1011) wip_left = (plan.size() > 0) ? plan.pop_front() : 0;
                  wip_now = wip_stuck || (wip_left > 0);
                  if (wip_left > 0) wip_left--;
               end
               prev_ct = cmd_type;
            end
         end else begin
            if ({cmd_type, flash_cmd, flash_addr} !== cap) hold_err++;
            if (m_wait > 0) begin
               m_wait--;
            end else if (m_idx < n_bytes) begin
               myvalid_o = 1'b1;
               mydata_o = model_byte(cap, m_idx);
               m_idx++;
            end else begin
               Done_Sig = 1'b1;
               if (cap[35:32] == 4'b1011) mydata_o = {7'd0, wip_now};
               m_act = 0;
               zero_chk = 1;
            end
         end
      end
   end

   task automatic reset_cfg();
      model_id = 24'hEF4017; read_len = 256; wip_stuck = 0; spurious = 0; corrupt_en = 0;
      corrupt_page = 24'h0; corrupt_idx = 0; prev_ct = 4'd0; wip_left = 0;
      plan.delete(); plan_ref.delete(); cmd_log.delete(); exp_q.delete(); hold_err = 0;
   endtask

   task automatic set_plan();
      for (int k = 0; k < 2 + 2 * NPG; k++) begin
         int n;
         n = $urandom_range(0, 3);
         plan.push_back(n);
         plan_ref.push_back(n);
      end
   endtask

   task automatic add_wait(inout int w);
      int n;
      n = (w < plan_ref.size()) ? plan_ref[w] : 0;
      for (int k = 0; k <= n; k++) exp_q.push_back({4'b1011, 8'h05, 24'h0});
      w++;
   endtask

   // Expected command stream for a complete run, derived from the sequence rules.
   task automatic build_exp();
      int w;
      w = 0;
      exp_q.delete();
      exp_q.push_back({4'b1000, 8'h9F, 24'h0});
      exp_q.push_back({4'b1001, 8'h06, 24'h0});
      exp_q.push_back({4'b1010, 8'hD8, BASE});
      add_wait(w);
      exp_q.push_back({4'b1100, 8'h04, 24'h0});
      add_wait(w);
      for (int p = 0; p < NPG; p++) begin
         exp_q.push_back({4'b1001, 8'h06, 24'h0});
         exp_q.push_back({4'b1101, 8'h02, BASE + 24'(p * 256)});
         add_wait(w);
         exp_q.push_back({4'b1100, 8'h04, 24'h0});
         add_wait(w);
      end
      for (int p = 0; p < NPG; p++) exp_q.push_back({4'b1110, 8'h03, BASE + 24'(p * 256)});
   endtask

   function automatic int log_diff();
      if (cmd_log.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (cmd_log[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   task automatic run_once(input bit extra, output bit got, output int pulses,
                           output logic pass_s, output logic busy_s);
      got = 0; pulses = 0;
      @(negedge CLK); start = 1'b1;
      @(negedge CLK); start = 1'b0;
      pass_s = pass; busy_s = busy;
      for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
         @(negedge CLK);
         start = extra && (cyc % 29 == 7);
         if (done) begin got = 1; pulses++; end
      end
      start = 1'b0;
      repeat (4) begin @(negedge CLK); if (done) pulses++; end
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      repeat (3) @(negedge CLK);
      total++; if ({busy, done, pass} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, pass}); end
      total++; if (err_code !== 3'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_code); end
      total++; if (fail_addr !== 24'd0) begin bad++; $display("FAIL reset_fail_addr got=%h want=0", fail_addr); end
      total++; if (id_o !== 24'd0) begin bad++; $display("FAIL reset_id got=%h want=0", id_o); end
      total++; if ({cmd_type, flash_cmd, flash_addr} !== 36'd0) begin bad++; $display("FAIL reset_cmd got=%h want=0", {cmd_type, flash_cmd, flash_addr}); end
      @(posedge CLK); #2 RSTn = 1'b1;
   endtask

   task automatic test_clean_run(input string name, input bit extra, input bit spur);
      bit got; int pulses; logic ps, bs; int d;
      reset_cfg(); spurious = spur; set_plan(); build_exp();
      run_once(extra, got, pulses, ps, bs);
      d = log_diff();
      total++; if (!got) begin bad++; $display("FAIL %s done_timeout got=0 want=1", name); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d want=1", name, pulses); end
      total++; if (bs !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", name, bs); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL %s pass got=%b want=1", name, pass); end
      total++; if (err_code !== 3'd0) begin bad++; $display("FAIL %s err_code got=%0d want=0", name, err_code); end
      total++; if (id_o !== 24'hEF4017) begin bad++; $display("FAIL %s id got=%h want=EF4017", name, id_o); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_end got=%b want=0", name, busy); end
      total++; if (d != -1) begin bad++; $display("FAIL %s cmd_stream diff=%0d got_len=%0d want_len=%0d", name, d, cmd_log.size(), exp_q.size()); end
      total++; if (hold_err != 0) begin bad++; $display("FAIL %s handshake got=%0d want=0", name, hold_err); end
   endtask

   task automatic test_id_mismatch();
      bit got; int pulses; logic ps, bs;
      reset_cfg(); model_id = 24'hC22017; set_plan();
      exp_q.push_back({4'b1000, 8'h9F, 24'h0});
      run_once(0, got, pulses, ps, bs);
      total++; if (ps !== 1'b0) begin bad++; $display("FAIL id_pass_cleared got=%b want=0", ps); end
      total++; if (!got) begin bad++; $display("FAIL id_done_timeout got=0 want=1"); end
      total++; if (err_code !== 3'd1) begin bad++; $display("FAIL id_err got=%0d want=1", err_code); end
      total++; if (id_o !== 24'hC22017) begin bad++; $display("FAIL id_capture got=%h want=C22017", id_o); end
      total++; if ({pass, busy} !== 2'b00) begin bad++; $display("FAIL id_flags got=%b want=00", {pass, busy}); end
      total++; if (log_diff() != -1) begin bad++; $display("FAIL id_cmd_stream got_len=%0d want_len=1", cmd_log.size()); end
   endtask

   task automatic test_poll_timeout();
      bit got; int pulses; logic ps, bs;
      reset_cfg(); wip_stuck = 1; set_plan(); build_exp();
      while (exp_q.size() > 11) void'(exp_q.pop_back());
      for (int k = 3; k < 11; k++) exp_q[k] = {4'b1011, 8'h05, 24'h0};
      run_once(0, got, pulses, ps, bs);
      total++; if (!got) begin bad++; $display("FAIL timeout_done got=0 want=1"); end
      total++; if (err_code !== 3'd2) begin bad++; $display("FAIL timeout_err got=%0d want=2", err_code); end
      total++; if ({pass, busy} !== 2'b00) begin bad++; $display("FAIL timeout_flags got=%b want=00", {pass, busy}); end
      total++; if (log_diff() != -1) begin bad++; $display("FAIL timeout_cmd_stream diff=%0d got_len=%0d want_len=11", log_diff(), cmd_log.size()); end
   endtask

   task automatic test_data_mismatch();
      bit got; int pulses; logic ps, bs;
      reset_cfg(); corrupt_en = 1; corrupt_page = BASE + 24'h000100; corrupt_idx = 8'h37;
      set_plan(); build_exp();
      run_once(0, got, pulses, ps, bs);
      total++; if (err_code !== 3'd3) begin bad++; $display("FAIL mismatch_err got=%0d want=3", err_code); end
      total++; if (fail_addr !== 24'h000137) begin bad++; $display("FAIL mismatch_addr got=%h want=000137", fail_addr); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL mismatch_pass got=%b want=0", pass); end
      total++; if (log_diff() != -1) begin bad++; $display("FAIL mismatch_cmd_stream diff=%0d", log_diff()); end
   endtask

   task automatic test_short_read();
      bit got; int pulses; logic ps, bs;
      reset_cfg(); read_len = 255; set_plan(); build_exp();
      void'(exp_q.pop_back());
      run_once(0, got, pulses, ps, bs);
      total++; if (err_code !== 3'd4) begin bad++; $display("FAIL short_err got=%0d want=4", err_code); end
      total++; if ({pass, busy} !== 2'b00) begin bad++; $display("FAIL short_flags got=%b want=00", {pass, busy}); end
      total++; if (log_diff() != -1) begin bad++; $display("FAIL short_cmd_stream diff=%0d", log_diff()); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      reset_cfg(); set_plan();
      @(negedge CLK); start = 1'b1;
      @(negedge CLK); start = 1'b0;
      seen = 0;
      for (int c = 0; c < 5000 && !seen; c++) begin
         @(negedge CLK);
         if (cmd_type == 4'b1101) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rstmid_reach_pp got=0 want=1"); end
      @(posedge CLK); #2 RSTn = 1'b0; #1;
      total++; if ({busy, done, pass, err_code} !== 6'd0) begin bad++; $display("FAIL rstmid_status got=%b want=0", {busy, done, pass, err_code}); end
      total++; if ({fail_addr, id_o} !== 48'd0) begin bad++; $display("FAIL rstmid_regs got=%h want=0", {fail_addr, id_o}); end
      total++; if ({cmd_type, flash_cmd, flash_addr} !== 36'd0) begin bad++; $display("FAIL rstmid_cmd got=%h want=0", {cmd_type, flash_cmd, flash_addr}); end
      repeat (3) @(negedge CLK);
      @(posedge CLK); #2 RSTn = 1'b1;
      test_clean_run("after_reset", 0, 0);
   endtask

   initial begin
      reset_cfg();
      test_reset();
      test_clean_run("clean", 0, 0);
      test_id_mismatch();
      test_poll_timeout();
      test_data_mismatch();
      test_short_read();
      test_clean_run("back_to_back_start", 1, 0);
      test_clean_run("spurious_done", 0, 1);
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
